// File: rtl/seven_seg_scan_driver_pkg.sv
// Shared types and segment tables for the seven-segment scan driver.
// Patterns are active-high with segment a in the MSB: {a,b,c,d,e,f,g}.
package seven_seg_pkg;

  typedef logic [3:0] nibble_t;
  typedef logic [6:0] seg_t;

  // All segments dark (active-high form).
  localparam seg_t SEG_BLANK = 7'h00;

  // Hex glyphs 0..F: 0 1 2 3 4 5 6 7 8 9 A b C d E F.
  localparam seg_t SEG_HEX [16] = '{
    7'h7E, 7'h30, 7'h6D, 7'h79,
    7'h33, 7'h5B, 7'h5F, 7'h70,
    7'h7F, 7'h7B, 7'h77, 7'h1F,
    7'h4E, 7'h3D, 7'h4F, 7'h47
  };

  // Width of a counter that must hold values 0..n-1 (never zero bits wide).
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seven_seg_scan_driver_if.sv
// Bundle of the driver's data inputs and pin outputs.
// Handshake: load is a single-cycle strobe with no ready; it is always
// accepted on the rising edge where it is high, and the data fields are
// sampled on that same edge. The display-side outputs are free-running.
interface seven_seg_scan_driver_if
  import seven_seg_pkg::*;
#(
  parameter int DIGITS = 3
);

  localparam int IDX_W = cnt_width(DIGITS);

  logic [4*DIGITS-1:0] digits_in;
  logic [DIGITS-1:0]   dots_in;
  logic [DIGITS-1:0]   blank_in;
  logic                lz_blank;
  logic                load;

  logic [DIGITS-1:0]   en_n;
  logic [6:0]          seg_n;
  logic                dp_n;
  logic                frame_done;
  logic [IDX_W-1:0]    dbg_idx;

  // Producer side: datapath block that feeds values to the display.
  modport master (
    output digits_in, dots_in, blank_in, lz_blank, load,
    input  en_n, seg_n, dp_n, frame_done, dbg_idx
  );

  // Driver side.
  modport slave (
    input  digits_in, dots_in, blank_in, lz_blank, load,
    output en_n, seg_n, dp_n, frame_done, dbg_idx
  );

endinterface

// File: rtl/seven_seg_scan_driver_seg_hex_decode.sv
// Combinational nibble to active-high seven-segment glyph.
module seg_hex_decode
  import seven_seg_pkg::*;
(
  input  nibble_t nib_i,
  output seg_t    seg_o
);

  // Table lookup of the hex glyph.
  always_comb seg_o = SEG_HEX[nib_i];

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed common-anode seven-segment driver.
// A prescaler defines digit slots; each slot starts with DEAD cycles of all
// enables off. Loaded values sit in a pending register and are promoted to
// the active register only when the scan wraps, so a frame never tears.
module seven_seg_scan_driver
  import seven_seg_pkg::*;
#(
  parameter int DIGITS      = 3,
  parameter int REFRESH_DIV = 4000,
  parameter int DEAD        = 2
)(
  input  logic                   clk,
  input  logic                   rst_n,
  seven_seg_scan_driver_if.slave bus
);

  localparam int CNT_W = cnt_width(REFRESH_DIV);
  localparam int IDX_W = cnt_width(DIGITS);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_DEAD = CNT_W'(DEAD);
  localparam logic [IDX_W-1:0] IDX_MAX  = IDX_W'(DIGITS - 1);

  // Scan timing
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             tick;
  logic             wrap;

  // Shadow (pending) and active display registers
  logic [4*DIGITS-1:0] pend_dig_q, pend_dig_d;
  logic [DIGITS-1:0]   pend_dot_q, pend_dot_d;
  logic [DIGITS-1:0]   pend_blk_q, pend_blk_d;
  logic                pend_v_q,   pend_v_d;
  logic [4*DIGITS-1:0] act_dig_q,  act_dig_d;
  logic [DIGITS-1:0]   act_dot_q,  act_dot_d;
  logic [DIGITS-1:0]   act_blk_q,  act_blk_d;

  // Current-digit selection
  nibble_t           cur_nib;
  logic              cur_dot;
  logic              cur_blk;
  logic              cur_lz;
  logic [DIGITS-1:0] lz_mask;
  logic              above_zero;
  seg_t              cur_pat;

  // Output registers
  logic [DIGITS-1:0] en_n_q, en_n_d;
  logic [6:0]        seg_n_q, seg_n_d;
  logic              dp_n_q, dp_n_d;
  logic              fd_q, fd_d;

  // Prescaler and digit index: tick ends a slot, wrap ends a frame.
  always_comb begin
    tick  = (cnt_q == CNT_MAX);
    wrap  = tick && (idx_q == IDX_MAX);
    cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
    idx_d = idx_q;
    if (tick) idx_d = wrap ? '0 : idx_q + IDX_W'(1);
  end

  // Shadow update: loads go to pending; the wrap promotes pending to active,
  // and a load coinciding with the wrap goes straight to active.
  always_comb begin
    pend_dig_d = pend_dig_q;
    pend_dot_d = pend_dot_q;
    pend_blk_d = pend_blk_q;
    pend_v_d   = pend_v_q;
    act_dig_d  = act_dig_q;
    act_dot_d  = act_dot_q;
    act_blk_d  = act_blk_q;
    if (bus.load) begin
      pend_dig_d = bus.digits_in;
      pend_dot_d = bus.dots_in;
      pend_blk_d = bus.blank_in;
      pend_v_d   = 1'b1;
    end
    if (wrap) begin
      pend_v_d = 1'b0;
      if (bus.load) begin
        act_dig_d = bus.digits_in;
        act_dot_d = bus.dots_in;
        act_blk_d = bus.blank_in;
      end else if (pend_v_q) begin
        act_dig_d = pend_dig_q;
        act_dot_d = pend_dot_q;
        act_blk_d = pend_blk_q;
      end
    end
  end

  // Leading-zero mask: a digit qualifies when it and every more-significant
  // digit are zero; digit 0 never qualifies.
  always_comb begin
    above_zero = 1'b1;
    lz_mask    = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      above_zero = above_zero && (act_dig_q[4*i +: 4] == 4'h0);
      lz_mask[i] = above_zero && (i != 0);
    end
  end

  // Pick the active-register fields of the digit being scanned.
  always_comb begin
    cur_nib = '0;
    cur_dot = 1'b0;
    cur_blk = 1'b0;
    cur_lz  = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (int'(idx_q) == i) begin
        cur_nib = act_dig_q[4*i +: 4];
        cur_dot = act_dot_q[i];
        cur_blk = act_blk_q[i];
        cur_lz  = lz_mask[i];
      end
    end
  end

  seg_hex_decode u_dec (
    .nib_i (cur_nib),
    .seg_o (cur_pat)
  );

  // Next pin values. Segments and dot are refreshed only in the first cycle
  // of a slot, so they settle while every enable is still off.
  always_comb begin
    en_n_d = '1;
    if (cnt_q >= CNT_DEAD) begin
      for (int i = 0; i < DIGITS; i++) begin
        if (int'(idx_q) == i) en_n_d[i] = 1'b0;
      end
    end
    fd_d    = wrap;
    seg_n_d = seg_n_q;
    dp_n_d  = dp_n_q;
    if (cnt_q == '0) begin
      seg_n_d = ~((cur_blk || (bus.lz_blank && cur_lz)) ? SEG_BLANK : cur_pat);
      dp_n_d  = ~(cur_dot && !cur_blk);
    end
  end

  // State and output registers; reset darkens the pins immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      idx_q      <= '0;
      pend_dig_q <= '0;
      pend_dot_q <= '0;
      pend_blk_q <= '0;
      pend_v_q   <= 1'b0;
      act_dig_q  <= '0;
      act_dot_q  <= '0;
      act_blk_q  <= '0;
      en_n_q     <= '1;
      seg_n_q    <= 7'h7F;
      dp_n_q     <= 1'b1;
      fd_q       <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      pend_dig_q <= pend_dig_d;
      pend_dot_q <= pend_dot_d;
      pend_blk_q <= pend_blk_d;
      pend_v_q   <= pend_v_d;
      act_dig_q  <= act_dig_d;
      act_dot_q  <= act_dot_d;
      act_blk_q  <= act_blk_d;
      en_n_q     <= en_n_d;
      seg_n_q    <= seg_n_d;
      dp_n_q     <= dp_n_d;
      fd_q       <= fd_d;
    end
  end

  assign bus.en_n       = en_n_q;
  assign bus.seg_n      = seg_n_q;
  assign bus.dp_n       = dp_n_q;
  assign bus.frame_done = fd_q;
  assign bus.dbg_idx    = idx_q;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Bench for seven_seg_scan_driver with DIGITS=3, REFRESH_DIV=8, DEAD=2.
// The reference model works from the edge count since reset release:
// slot = ((n-1)/8)%3, position in slot = (n-1)%8, wrap when n%24==0.
module tb_seven_seg_scan_driver;

  localparam int DIGITS = 3;
  localparam int RD     = 8;
  localparam int DEAD   = 2;
  localparam int FRAME  = DIGITS * RD;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  int vectors     = 0;
  int miscompares = 0;

  // Clock / reset
  always #5 clk = ~clk;

  seven_seg_scan_driver_if #(.DIGITS(DIGITS)) bus ();

  seven_seg_scan_driver #(
    .DIGITS      (DIGITS),
    .REFRESH_DIV (RD),
    .DEAD        (DEAD)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Active-high glyph table 0..F.
  logic [6:0] hex_tab [16] = '{
    7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
    7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
  };

  // Reference model state
  int          m_n       = 0;
  logic [11:0] m_act_d   = '0;
  logic [2:0]  m_act_dot = '0;
  logic [2:0]  m_act_blk = '0;
  logic [11:0] m_pend_d  = '0;
  logic [2:0]  m_pend_dot = '0;
  logic [2:0]  m_pend_blk = '0;
  logic        m_pend_v  = 1'b0;
  logic [2:0]  exp_en    = 3'b111;
  logic [6:0]  exp_seg   = 7'h7F;
  logic        exp_dp    = 1'b1;
  logic        exp_fd    = 1'b0;

  logic [6:0] prev_seg = 7'h7F;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] model_seg(input int s, input logic lz);
    logic [11:0] upper;
    upper = m_act_d >> (4 * s);
    if (m_act_blk[s]) return 7'h7F;
    if (lz && s != 0 && upper == 12'h0) return 7'h7F;
    return ~hex_tab[upper[3:0]];
  endfunction

  // Reference model: outputs after edge n come from the state before it.
  always @(posedge clk or negedge rst_n) begin : model
    int e, pos, slot;
    if (!rst_n) begin
      m_n       <= 0;
      m_act_d   <= '0;
      m_act_dot <= '0;
      m_act_blk <= '0;
      m_pend_v  <= 1'b0;
      exp_en    <= 3'b111;
      exp_seg   <= 7'h7F;
      exp_dp    <= 1'b1;
      exp_fd    <= 1'b0;
    end else begin
      e    = m_n + 1;
      pos  = (e - 1) % RD;
      slot = ((e - 1) / RD) % DIGITS;
      m_n    <= e;
      exp_en <= (pos >= DEAD) ? ~(3'b001 << slot) : 3'b111;
      exp_fd <= (e % FRAME == 0);
      if (pos == 0) begin
        exp_seg <= model_seg(slot, bus.lz_blank);
        exp_dp  <= !(m_act_dot[slot] && !m_act_blk[slot]);
      end
      if (e % FRAME == 0) begin
        m_pend_v <= 1'b0;
        if (bus.load) begin
          m_act_d   <= bus.digits_in;
          m_act_dot <= bus.dots_in;
          m_act_blk <= bus.blank_in;
        end else if (m_pend_v) begin
          m_act_d   <= m_pend_d;
          m_act_dot <= m_pend_dot;
          m_act_blk <= m_pend_blk;
        end
      end else if (bus.load) begin
        m_pend_d   <= bus.digits_in;
        m_pend_dot <= bus.dots_in;
        m_pend_blk <= bus.blank_in;
        m_pend_v   <= 1'b1;
      end
    end
  end

  // Scoreboard compare on every falling edge, plus dead-time invariants.
  always @(negedge clk) begin
    chk("en_n", bus.en_n, exp_en);
    chk("seg_n", bus.seg_n, exp_seg);
    chk("dp_n", bus.dp_n, exp_dp);
    chk("frame_done", bus.frame_done, exp_fd);
    chk("one_enable", ($countones(~bus.en_n) <= 1), 1);
    if (bus.en_n != 3'b111) chk("seg_stable_while_enabled", bus.seg_n, prev_seg);
    prev_seg = bus.seg_n;
  end

  // Driver tasks
  task automatic do_load(input logic [11:0] d, input logic [2:0] dots, input logic [2:0] blk);
    @(negedge clk);
    bus.digits_in = d;
    bus.dots_in   = dots;
    bus.blank_in  = blk;
    bus.load      = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
  endtask

  task automatic wait_frame();
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (bus.frame_done !== 1'b1 && k < 3 * FRAME);
    chk("frame_wait", bus.frame_done, 1);
  endtask

  task automatic check_frame(input string nm, input logic [6:0] s0, input logic [6:0] s1,
                             input logic [6:0] s2, input logic [2:0] dpn);
    wait_frame();
    repeat (4) @(negedge clk);
    chk({nm, " seg slot0"}, bus.seg_n, s0);
    chk({nm, " dp slot0"}, bus.dp_n, dpn[0]);
    repeat (8) @(negedge clk);
    chk({nm, " seg slot1"}, bus.seg_n, s1);
    chk({nm, " dp slot1"}, bus.dp_n, dpn[1]);
    repeat (8) @(negedge clk);
    chk({nm, " seg slot2"}, bus.seg_n, s2);
    chk({nm, " dp slot2"}, bus.dp_n, dpn[2]);
  endtask

  initial begin
    bus.digits_in = '0;
    bus.dots_in   = '0;
    bus.blank_in  = '0;
    bus.lz_blank  = 1'b0;
    bus.load      = 1'b0;
    #1 rst_n = 1'b0;

    // Reset values and scan timing from release
    @(negedge clk);
    chk("rst en_n", bus.en_n, 3'b111);
    chk("rst seg_n", bus.seg_n, 7'h7F);
    chk("rst dp_n", bus.dp_n, 1);
    chk("rst frame_done", bus.frame_done, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("edge2 en_n", bus.en_n, 3'b111);
    @(negedge clk);
    chk("edge3 en_n", bus.en_n, 3'b110);
    repeat (5) @(negedge clk);
    chk("edge8 en_n", bus.en_n, 3'b110);
    @(negedge clk);
    chk("edge9 en_n", bus.en_n, 3'b111);
    repeat (2) @(negedge clk);
    chk("edge11 en_n", bus.en_n, 3'b101);
    repeat (13) @(negedge clk);
    chk("edge24 frame_done", bus.frame_done, 1);
    @(negedge clk);
    chk("edge25 frame_done", bus.frame_done, 0);
    repeat (23) @(negedge clk);
    chk("edge48 frame_done", bus.frame_done, 1);

    // Mid-slot reset with a pending load that must be lost
    do_load(12'hFFF, 3'b111, 3'b000);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst en_n", bus.en_n, 3'b111);
    chk("midrst seg_n", bus.seg_n, 7'h7F);
    chk("midrst dp_n", bus.dp_n, 1);
    chk("midrst frame_done", bus.frame_done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("post-rst digit0", bus.seg_n, 7'b0000001);
    chk("post-rst en_n", bus.en_n, 3'b110);

    // Load and decode
    do_load(12'h1A5, 3'b000, 3'b000);
    check_frame("1A5", 7'b0100100, 7'b0001000, 7'b1001111, 3'b111);

    // Shadowing: mid-frame load stays hidden until the wrap
    do_load(12'h123, 3'b000, 3'b000);
    wait_frame();
    repeat (4) @(negedge clk);
    chk("123 slot0", bus.seg_n, 7'b0000110);
    do_load(12'h456, 3'b000, 3'b000);
    repeat (6) @(negedge clk);
    chk("123 slot1 after new load", bus.seg_n, 7'b0010010);
    repeat (8) @(negedge clk);
    chk("123 slot2 after new load", bus.seg_n, 7'b1001111);
    check_frame("456", 7'b0100000, 7'b0100100, 7'b1001100, 3'b111);

    // Load on the wrap cycle becomes active in the same frame
    wait_frame();
    repeat (23) @(negedge clk);
    bus.digits_in = 12'h789;
    bus.load      = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
    chk("wrap-load frame_done", bus.frame_done, 1);
    repeat (4) @(negedge clk);
    chk("wrap-load slot0", bus.seg_n, 7'b0000100);
    repeat (8) @(negedge clk);
    chk("wrap-load slot1", bus.seg_n, 7'b0000000);

    // Leading-zero blanking
    bus.lz_blank = 1'b1;
    do_load(12'h007, 3'b000, 3'b000);
    check_frame("lz 007", 7'b0001111, 7'h7F, 7'h7F, 3'b111);
    do_load(12'h000, 3'b000, 3'b000);
    check_frame("lz 000", 7'b0000001, 7'h7F, 7'h7F, 3'b111);
    do_load(12'h070, 3'b000, 3'b000);
    check_frame("lz 070", 7'b0000001, 7'b0001111, 7'h7F, 3'b111);

    // Dots and blank
    bus.lz_blank = 1'b0;
    do_load(12'h1A5, 3'b101, 3'b100);
    check_frame("dots", 7'b0100100, 7'b0001000, 7'h7F, 3'b110);

    // Randomized loads and lz toggles over 12 frames
    for (int i = 0; i < 12 * FRAME; i++) begin
      @(negedge clk);
      bus.load = ($urandom_range(0, 11) == 0);
      if (bus.load) begin
        bus.digits_in = 12'($urandom_range(0, 4095));
        bus.dots_in   = 3'($urandom_range(0, 7));
        bus.blank_in  = 3'($urandom_range(0, 7));
        if ($urandom_range(0, 1) == 0) bus.digits_in[11:4] = 8'h00;
      end
      if ($urandom_range(0, 29) == 0) bus.lz_blank = ~bus.lz_blank;
    end
    @(negedge clk);
    bus.load = 1'b0;
    repeat (2 * FRAME) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Watchdog
  initial begin
    #200000;
    miscompares++;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
